// File: rtl/divclk_pkg.sv
// Shared types and constants for the programmable fractional clock/tick divider.
package divclk_pkg;

   // Divider run state.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Smallest integer divisor that still yields a distinct high and low phase.
   localparam int MIN_DIV = 2;

   // Default widths of the integer divisor/period counter and of the fraction.
   localparam int DEF_CNT_W  = 16;
   localparam int DEF_FRAC_W = 4;

endpackage : divclk_pkg

// File: rtl/divclk_frac_acc.sv
// Fractional phase accumulator: adds the fractional divisor once per period
// and reports the carry that stretches the next period by one cycle.
module divclk_frac_acc
   import divclk_pkg::*;
#(
   parameter int FRAC_W = DEF_FRAC_W
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              clr,    // stop or phase restart: accumulator back to 0
   input  logic              load,   // entering RUN: accumulator starts at the fraction
   input  logic              step,   // period boundary: accumulate the fraction
   input  logic [FRAC_W-1:0] add,    // fraction to load or accumulate
   output logic              carry   // carry out of acc + add
);

   logic [FRAC_W-1:0] acc_q;
   logic [FRAC_W-1:0] acc_d;
   logic [FRAC_W-1:0] sum;

   // Sum is one bit wider than the accumulator so the overflow becomes the carry.
   assign {carry, sum} = {1'b0, acc_q} + {1'b0, add};

   // Next accumulator value; clear wins over load, load wins over step.
   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (load) begin
         acc_d = add;
      end else if (step) begin
         acc_d = sum;
      end
   end

   // Accumulator register.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         acc_q <= acc_d;
      end
   end

endmodule : divclk_frac_acc

// File: rtl/divclk_prog.sv
// Runtime-programmable fractional clock/tick divider with a valid/ready
// divisor reload that takes effect only at period boundaries.
module divclk_prog
   import divclk_pkg::*;
#(
   parameter int CNT_W        = DEF_CNT_W,
   parameter int FRAC_W       = DEF_FRAC_W,
   parameter int DEFAULT_DIV  = 10,
   parameter int DEFAULT_FRAC = 0
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              en,
   input  logic              sync_clr,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic [FRAC_W-1:0] cfg_frac,
   output logic              cfg_err,
   output logic              clk_out,
   output logic              tick
);

   localparam logic [CNT_W:0]    LEN_ONE   = (CNT_W+1)'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  MIN_DIV_V = CNT_W'(MIN_DIV);
   localparam logic [CNT_W-1:0]  RST_DIV   = CNT_W'(DEFAULT_DIV);
   localparam logic [FRAC_W-1:0] RST_FRAC  = FRAC_W'(DEFAULT_FRAC);

   // Registered state.
   state_e              state_q,   state_d;
   logic [CNT_W-1:0]    count_q,   count_d;
   logic [CNT_W:0]      len_q,     len_d;     // one extra bit: max divisor plus carry fits
   logic [CNT_W-1:0]    div_q,     div_d;
   logic [FRAC_W-1:0]   frac_q,    frac_d;
   logic                pend_q,    pend_d;
   logic [CNT_W-1:0]    pdiv_q,    pdiv_d;
   logic [FRAC_W-1:0]   pfrac_q,   pfrac_d;
   logic                clk_out_q, clk_out_d;
   logic                tick_q,    tick_d;
   logic                cfg_err_q, cfg_err_d;

   // Combinational helpers.
   logic [CNT_W-1:0]    nxt_div;
   logic [FRAC_W-1:0]   nxt_frac;
   logic                boundary;
   logic                cfg_fire;
   logic                cfg_bad;
   logic                cfg_ok;
   logic                direct;
   logic                acc_clr;
   logic                acc_load;
   logic                acc_step;
   logic [FRAC_W-1:0]   acc_add;
   logic                acc_carry;

   divclk_frac_acc #(
      .FRAC_W (FRAC_W)
   ) u_frac_acc (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .clr    (acc_clr),
      .load   (acc_load),
      .step   (acc_step),
      .add    (acc_add),
      .carry  (acc_carry)
   );

   // A request can only be taken while no reload is waiting for its boundary.
   assign cfg_ready = ~pend_q;
   assign cfg_err   = cfg_err_q;
   assign clk_out   = clk_out_q;
   assign tick      = tick_q;

   // Next-state logic: run control, config handshake, period length and outputs.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d   = state_q;
      count_d   = count_q;
      len_d     = len_q;
      div_d     = div_q;
      frac_d    = frac_q;
      pend_d    = pend_q;
      pdiv_d    = pdiv_q;
      pfrac_d   = pfrac_q;
      acc_clr   = 1'b0;
      acc_load  = 1'b0;
      acc_step  = 1'b0;
      acc_add   = frac_q;

      // Values for the next period: a waiting reload replaces the live divisor.
      nxt_div  = pend_q ? pdiv_q  : div_q;
      nxt_frac = pend_q ? pfrac_q : frac_q;
      boundary = (state_q == ST_RUN) && ({1'b0, count_q} == (len_q - LEN_ONE));

      cfg_fire  = cfg_valid && !pend_q;
      cfg_bad   = cfg_fire && (cfg_div < MIN_DIV_V);
      cfg_ok    = cfg_fire && !cfg_bad;
      cfg_err_d = cfg_bad;
      // Idle or stopping: nothing is mid-period, so a new divisor can land at once.
      direct    = (state_q == ST_IDLE) || !en;

      // Stop, restart and boundary all retire a waiting reload.
      if (!en || sync_clr || boundary) begin
         div_d  = nxt_div;
         frac_d = nxt_frac;
         pend_d = 1'b0;
      end

      // Accept after retiring, so a same-cycle request waits for the next boundary.
      if (cfg_ok) begin
         if (direct) begin
            div_d  = cfg_div;
            frac_d = cfg_frac;
         end else begin
            pend_d  = 1'b1;
            pdiv_d  = cfg_div;
            pfrac_d = cfg_frac;
         end
      end

      if (!en) begin
         state_d = ST_IDLE;
         count_d = '0;
         acc_clr = 1'b1;
         len_d   = {1'b0, div_d};
      end else if (sync_clr) begin
         state_d = ST_RUN;
         count_d = '0;
         acc_clr = 1'b1;
         len_d   = {1'b0, div_d};
      end else if (state_q == ST_IDLE) begin
         state_d  = ST_RUN;
         count_d  = '0;
         acc_load = 1'b1;
         acc_add  = frac_d;
         len_d    = {1'b0, div_d};
      end else if (boundary) begin
         count_d  = '0;
         acc_step = 1'b1;
         acc_add  = nxt_frac;
         len_d    = {1'b0, nxt_div} + {{CNT_W{1'b0}}, acc_carry};
      end else begin
         count_d = count_q + CNT_ONE;
      end

      // Outputs follow the next count/len so they line up with the registered state.
      clk_out_d = (state_d == ST_RUN) && ({1'b0, count_d} < (len_d >> 1));
      tick_d    = (state_d == ST_RUN) && ({1'b0, count_d} == (len_d - LEN_ONE));
   end

   // State, configuration and output registers.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         len_q     <= {1'b0, RST_DIV};
         div_q     <= RST_DIV;
         frac_q    <= RST_FRAC;
         pend_q    <= 1'b0;
         pdiv_q    <= '0;
         pfrac_q   <= '0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         len_q     <= len_d;
         div_q     <= div_d;
         frac_q    <= frac_d;
         pend_q    <= pend_d;
         pdiv_q    <= pdiv_d;
         pfrac_q   <= pfrac_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
         cfg_err_q <= cfg_err_d;
      end
   end

endmodule : divclk_prog
